// File: rtl/bin_op_fold_if.sv
// BinOp: two-operand combinational operation interface.
//   Injected modport - initiator side: drives lhs/rhs, reads result.
//   Impl modport     - implementation side: reads lhs/rhs, drives result.
// Data paths are OPERAND_WIDTH+1 bits wide ([OPERAND_WIDTH:0]).
// Also holds two reference Impl modules (add, and) that any Injected
// user can plug in.
interface BinOp #(
  parameter int OPERAND_WIDTH = 8
);
  logic [OPERAND_WIDTH:0] lhs;
  logic [OPERAND_WIDTH:0] rhs;
  logic [OPERAND_WIDTH:0] result;

  modport Injected (output lhs, output rhs, input result);
  modport Impl     (input lhs, input rhs, output result);
endinterface

// bin_op_add: result = lhs + rhs, wrapping at the data width.
module bin_op_add (
  BinOp.Impl op
);
  always_comb begin
    op.result = op.lhs + op.rhs;
  end
endmodule

// bin_op_and: result = lhs & rhs.
module bin_op_and (
  BinOp.Impl op
);
  always_comb begin
    op.result = op.lhs & op.rhs;
  end
endmodule

// File: rtl/bin_op_fold.sv
// bin_op_fold: streaming left-to-right reducer over an injected BinOp.
//   acc = op(op(op(x0, x1), x2), ...), reported with element count.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   op               - BinOp.Injected; lhs=acc, rhs=in_data, result sampled
//   in_valid/ready   - operand handshake; in_data operand, in_last ends seq
//   out_valid/ready  - result handshake; out_data folded value,
//                      out_count number of elements (saturating)
module bin_op_fold #(
  parameter int OPERAND_WIDTH = 8,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  BinOp.Injected                 op,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPERAND_WIDTH:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPERAND_WIDTH:0] out_data,
  output logic [COUNT_WIDTH-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [OPERAND_WIDTH:0] acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic in_xfer;
  logic out_xfer;

  always_comb begin
    op.lhs = acc_q;
    op.rhs = in_data;
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
    out_data  = acc_q;
    out_count = count_q;
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          // First element is loaded directly; the op is not applied.
          acc_d   = in_data;
          count_d = COUNT_WIDTH'(1);
          state_d = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_xfer) begin
          acc_d   = op.result;
          count_d = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);
          if (in_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_bin_op_fold.sv
module tb_bin_op_fold;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_last;
  logic       out_ready;

  // dut0: adder, 8-bit count; dut1: adder, 2-bit count; dut2: AND, 2-bit count
  logic       in_ready0, out_valid0;
  logic [8:0] out_data0;
  logic [7:0] out_count0;
  logic       in_ready1, out_valid1;
  logic [8:0] out_data1;
  logic [1:0] out_count1;
  logic       in_ready2, out_valid2;
  logic [8:0] out_data2;
  logic [1:0] out_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  BinOp #(.OPERAND_WIDTH(8)) op0 ();
  BinOp #(.OPERAND_WIDTH(8)) op1 ();
  BinOp #(.OPERAND_WIDTH(8)) op2 ();

  bin_op_add u_add0 (.op(op0));
  bin_op_add u_add1 (.op(op1));
  bin_op_and u_and2 (.op(op2));

  bin_op_fold #(.OPERAND_WIDTH(8), .COUNT_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .op(op0),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0)
  );

  bin_op_fold #(.OPERAND_WIDTH(8), .COUNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .op(op1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1)
  );

  bin_op_fold #(.OPERAND_WIDTH(8), .COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .op(op2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 9'h000, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready0); end
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
    tests++; if (out_data0 !== 9'h000) begin fails++; $display("FAIL reset_out_data got=%h exp=000", out_data0); end
    tests++; if (out_count0 !== 8'd0) begin fails++; $display("FAIL reset_out_count got=%0d exp=0", out_count0); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive(1'b1, 9'd3, 1'b0); tick();
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL stream_no_early_valid got=%b exp=0", out_valid0); end
    drive(1'b1, 9'd4, 1'b0); tick();
    drive(1'b1, 9'd5, 1'b1); tick();
    drive(1'b0, 9'd0, 1'b0);
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL stream_out_valid got=%b exp=1", out_valid0); end
    tests++; if (out_data0 !== 9'd12) begin fails++; $display("FAIL stream_out_data got=%0d exp=12", out_data0); end
    tests++; if (out_count0 !== 8'd3) begin fails++; $display("FAIL stream_out_count got=%0d exp=3", out_count0); end
    tests++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL stream_in_ready_done got=%b exp=0", in_ready0); end
    tick();
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL stream_in_ready_back got=%b exp=1", in_ready0); end
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL stream_out_valid_drop got=%b exp=0", out_valid0); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 9'h1FF, 1'b1); tick();
    drive(1'b0, 9'h000, 1'b0);
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL single_out_valid got=%b exp=1", out_valid0); end
    tests++; if (out_data0 !== 9'h1FF) begin fails++; $display("FAIL single_out_data got=%h exp=1ff", out_data0); end
    tests++; if (out_count0 !== 8'd1) begin fails++; $display("FAIL single_out_count got=%0d exp=1", out_count0); end
    tick();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    drive(1'b1, 9'h1FF, 1'b0); tick();
    drive(1'b1, 9'h002, 1'b1); tick();
    drive(1'b0, 9'h000, 1'b0);
    tests++; if (out_data0 !== 9'h001) begin fails++; $display("FAIL wrap_out_data got=%h exp=001", out_data0); end
    tests++; if (out_count0 !== 8'd2) begin fails++; $display("FAIL wrap_out_count got=%0d exp=2", out_count0); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 9'd3, 1'b1); tick();
    drive(1'b1, 9'd9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid0); end
      tests++; if (out_data0 !== 9'd3) begin fails++; $display("FAIL bp_out_data cyc=%0d got=%0d exp=3", i, out_data0); end
      tests++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready0); end
      tick();
    end
    out_ready = 1'b1;
    tests++; if (out_data0 !== 9'd3) begin fails++; $display("FAIL bp_hold_final got=%0d exp=3", out_data0); end
    tick();
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL bp_released got=%b exp=0", out_valid0); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL bp_ready_again got=%b exp=1", in_ready0); end
    tick();
    drive(1'b0, 9'd0, 1'b0);
    tests++; if (out_valid0 !== 1'b1 || out_data0 !== 9'd9) begin fails++; $display("FAIL bp_nine_consumed got=%b/%0d exp=1/9", out_valid0, out_data0); end
    tests++; if (out_count0 !== 8'd1) begin fails++; $display("FAIL bp_nine_count got=%0d exp=1", out_count0); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 9'd10, 1'b0); tick();
    drive(1'b1, 9'd20, 1'b0); tick();
    drive(1'b0, 9'd0, 1'b0);
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL mid_no_valid got=%b exp=0", out_valid0); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid0); end
    tests++; if (out_data0 !== 9'd0) begin fails++; $display("FAIL mid_rst_data got=%0d exp=0", out_data0); end
    tests++; if (out_count0 !== 8'd0) begin fails++; $display("FAIL mid_rst_count got=%0d exp=0", out_count0); end
    drive(1'b1, 9'd7, 1'b1); tick();
    drive(1'b0, 9'd0, 1'b0);
    tests++; if (out_data0 !== 9'd7) begin fails++; $display("FAIL mid_after_data got=%0d exp=7", out_data0); end
    tests++; if (out_count0 !== 8'd1) begin fails++; $display("FAIL mid_after_count got=%0d exp=1", out_count0); end
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'd1, (i == 4)); tick();
    end
    drive(1'b0, 9'd0, 1'b0);
    tests++; if (out_data1 !== 9'd5) begin fails++; $display("FAIL sat_out_data got=%0d exp=5", out_data1); end
    tests++; if (out_count1 !== 2'd3) begin fails++; $display("FAIL sat_out_count got=%0d exp=3", out_count1); end
    tests++; if (out_count0 !== 8'd5) begin fails++; $display("FAIL sat_wide_count got=%0d exp=5", out_count0); end
    tests++; if (out_data2 !== 9'd1) begin fails++; $display("FAIL sat_and_data got=%0d exp=1", out_data2); end
    tick();
  endtask

  task automatic test_and_op();
    out_ready = 1'b1;
    drive(1'b1, 9'h0F0, 1'b0); tick();
    drive(1'b1, 9'h03C, 1'b0); tick();
    drive(1'b1, 9'h1FF, 1'b1); tick();
    drive(1'b0, 9'h000, 1'b0);
    tests++; if (out_data2 !== 9'h030) begin fails++; $display("FAIL and_out_data got=%h exp=030", out_data2); end
    tests++; if (out_count2 !== 2'd3) begin fails++; $display("FAIL and_out_count got=%0d exp=3", out_count2); end
    // 0x0F0 + 0x03C + 0x1FF = 0x32B, wrapped to 9 bits
    tests++; if (out_data0 !== 9'h12B) begin fails++; $display("FAIL and_add_ref got=%h exp=12b", out_data0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_single();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_and_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
